// File: rtl/seat_query_reader.sv
// seat_query_reader
//   Read-side query engine for the seat table. A query either looks up one seat
//   directly or scans every seat for a student number. The table is read through
//   a port with one cycle of latency, and the result is held on a valid/ready
//   response channel until it is taken.
//
// Ports
//   clk, rst            rising-edge clock; synchronous active-high reset
//   query_*             request channel (valid/ready), sampled only at handshake
//   tbl_rd_en/addr      table read strobe and address
//   tbl_rd_*            table read data, valid the cycle after tbl_rd_en
//   resp_*              response channel (valid/ready); fields held while stalled
module seat_query_reader #(
  parameter int NUM_SEATS = 32,
  parameter int SEAT_W    = 5,
  parameter int STUDENT_W = 32,
  parameter int TIME_W    = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 query_valid,
  output logic                 query_ready,
  input  logic                 query_by_seat,
  input  logic [SEAT_W-1:0]    query_seat_no,
  input  logic [STUDENT_W-1:0] query_student_no,
  output logic                 tbl_rd_en,
  output logic [SEAT_W-1:0]    tbl_rd_addr,
  input  logic [STUDENT_W-1:0] tbl_rd_student_no,
  input  logic [1:0]           tbl_rd_state,
  input  logic [TIME_W-1:0]    tbl_rd_time,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_found,
  output logic [SEAT_W-1:0]    resp_seat_no,
  output logic [1:0]           resp_state,
  output logic [TIME_W-1:0]    resp_time
);

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN, RESP} state_t;

  localparam logic [SEAT_W-1:0] LAST_SEAT  = SEAT_W'(NUM_SEATS - 1);
  // One bit wider so NUM_SEATS == 2**SEAT_W still compares correctly.
  localparam logic [SEAT_W:0]   SEAT_LIMIT = (SEAT_W + 1)'(NUM_SEATS);

  state_t               state;
  logic                 q_by_seat;
  logic [STUDENT_W-1:0] q_student;
  // vld_pipe[0]: read issued this cycle; vld_pipe[1]: table data present this cycle.
  logic [1:0]           vld_pipe;
  logic [SEAT_W-1:0]    cmp_addr;   // address whose data is on tbl_rd_* now
  logic                 entry_live;
  logic                 scan_hit;

  assign tbl_rd_en   = vld_pipe[0];
  assign query_ready = (state == IDLE) && !rst;
  assign entry_live  = (tbl_rd_state != 2'd0);
  assign scan_hit    = vld_pipe[1] && entry_live && (tbl_rd_student_no == q_student);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      q_by_seat    <= 1'b0;
      q_student    <= '0;
      vld_pipe     <= '0;
      cmp_addr     <= '0;
      tbl_rd_addr  <= '0;
      resp_valid   <= 1'b0;
      resp_found   <= 1'b0;
      resp_seat_no <= '0;
      resp_state   <= '0;
      resp_time    <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      cmp_addr    <= tbl_rd_addr;
      case (state)
        IDLE: begin
          if (query_valid) begin
            q_by_seat    <= query_by_seat;
            q_student    <= query_student_no;
            resp_found   <= 1'b0;
            resp_seat_no <= '0;
            resp_state   <= '0;
            resp_time    <= '0;
            if (!query_by_seat) begin
              state       <= SCAN;
              vld_pipe[0] <= 1'b1;
              tbl_rd_addr <= '0;
            end else if ({1'b0, query_seat_no} < SEAT_LIMIT) begin
              state       <= DIRECT;
              vld_pipe[0] <= 1'b1;
              tbl_rd_addr <= query_seat_no;
            end else begin
              // Out-of-range seat: answer immediately with an all-zero miss.
              state      <= RESP;
              resp_valid <= 1'b1;
            end
          end
        end
        DIRECT: begin
          vld_pipe[0] <= 1'b0;
          if (vld_pipe[1]) begin
            // Direct lookups report the entry even when it is EMPTY.
            state        <= RESP;
            resp_valid   <= 1'b1;
            resp_found   <= entry_live;
            resp_seat_no <= cmp_addr;
            resp_state   <= tbl_rd_state;
            resp_time    <= tbl_rd_time;
          end
        end
        SCAN: begin
          if (scan_hit) begin
            // The read already in flight for the next seat is dropped.
            vld_pipe[0]  <= 1'b0;
            state        <= RESP;
            resp_valid   <= 1'b1;
            resp_found   <= 1'b1;
            resp_seat_no <= cmp_addr;
            resp_state   <= tbl_rd_state;
            resp_time    <= tbl_rd_time;
          end else if (vld_pipe[1] && (cmp_addr == LAST_SEAT)) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end else if (vld_pipe[0]) begin
            // Stop issuing at the last seat; the address never wraps.
            if (tbl_rd_addr == LAST_SEAT) vld_pipe[0] <= 1'b0;
            else                          tbl_rd_addr <= tbl_rd_addr + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seat_query_reader.sv
module tb_seat_query_reader;
  localparam int NS = 32, SW = 5, STW = 32, TW = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           query_valid = 1'b0, query_ready, query_by_seat = 1'b0;
  logic [SW-1:0]  query_seat_no = '0;
  logic [STW-1:0] query_student_no = '0;
  logic           tbl_rd_en;
  logic [SW-1:0]  tbl_rd_addr;
  logic [STW-1:0] rd_sn;
  logic [1:0]     rd_st;
  logic [TW-1:0]  rd_tm;
  logic           resp_valid, resp_ready = 1'b1, resp_found;
  logic [SW-1:0]  resp_seat_no;
  logic [1:0]     resp_state;
  logic [TW-1:0]  resp_time;

  // Second instance with a 20-entry table for the out-of-range boundary.
  logic           qv20 = 1'b0, qr20, en20, rv20, rr20 = 1'b1, found20;
  logic [SW-1:0]  addr20, seat20;
  logic [1:0]     state20;
  logic [TW-1:0]  time20;

  seat_query_reader #(.NUM_SEATS(NS), .SEAT_W(SW), .STUDENT_W(STW), .TIME_W(TW)) dut (
    .clk(clk), .rst(rst), .query_valid(query_valid), .query_ready(query_ready),
    .query_by_seat(query_by_seat), .query_seat_no(query_seat_no),
    .query_student_no(query_student_no), .tbl_rd_en(tbl_rd_en), .tbl_rd_addr(tbl_rd_addr),
    .tbl_rd_student_no(rd_sn), .tbl_rd_state(rd_st), .tbl_rd_time(rd_tm),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_found(resp_found),
    .resp_seat_no(resp_seat_no), .resp_state(resp_state), .resp_time(resp_time));

  seat_query_reader #(.NUM_SEATS(20), .SEAT_W(SW), .STUDENT_W(STW), .TIME_W(TW)) dut20 (
    .clk(clk), .rst(rst), .query_valid(qv20), .query_ready(qr20),
    .query_by_seat(query_by_seat), .query_seat_no(query_seat_no),
    .query_student_no(query_student_no), .tbl_rd_en(en20), .tbl_rd_addr(addr20),
    .tbl_rd_student_no(rd_sn), .tbl_rd_state(rd_st), .tbl_rd_time(rd_tm),
    .resp_valid(rv20), .resp_ready(rr20), .resp_found(found20),
    .resp_seat_no(seat20), .resp_state(state20), .resp_time(time20));

  // Seat table model: 1-cycle read latency, junk when not reading.
  logic [STW-1:0] t_sn [NS];
  logic [1:0]     t_st [NS];
  logic [TW-1:0]  t_tm [NS];
  always @(posedge clk) begin
    if (tbl_rd_en) begin
      rd_sn <= t_sn[tbl_rd_addr]; rd_st <= t_st[tbl_rd_addr]; rd_tm <= t_tm[tbl_rd_addr];
    end else begin
      rd_sn <= 32'hDEADBEEF; rd_st <= 2'd3; rd_tm <= '1;
    end
  end

  // Read monitor.
  logic [SW-1:0] rd_log [$];
  int en20_cnt = 0;
  always @(negedge clk) begin
    if (tbl_rd_en) rd_log.push_back(tbl_rd_addr);
    if (en20) en20_cnt++;
  end

  typedef struct {
    bit             by_seat;
    logic [SW-1:0]  seat;
    logic [STW-1:0] student;
    bit             e_found;
    logic [SW-1:0]  e_seat;
    logic [1:0]     e_state;
    logic [TW-1:0]  e_time;
    int             e_lat;
    int             e_reads;
  } vec_t;

  vec_t sb [$];
  vec_t vecs [7];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Issue one query to the 32-seat DUT and check the response, latency and reads.
  task automatic do_query(input vec_t v);
    int cyc, start, bad;
    bit got;
    vec_t e;
    @(negedge clk);
    chk("query_ready_idle", query_ready, 1);
    query_valid = 1'b1; query_by_seat = v.by_seat;
    query_seat_no = v.seat; query_student_no = v.student;
    sb.push_back(v);
    start = rd_log.size();
    @(posedge clk); #1;
    // Scramble inputs: the DUT must ignore them after the handshake.
    query_valid = 1'b0; query_by_seat = ~v.by_seat;
    query_seat_no = ~v.seat; query_student_no = ~v.student;
    cyc = 1; got = 1'b0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
      else begin @(posedge clk); cyc++; end
    end
    e = sb.pop_front();
    chk("resp_seen", got, 1);
    if (got) begin
      chk("latency", cyc, e.e_lat);
      chk("found", resp_found, e.e_found);
      chk("seat_no", resp_seat_no, e.e_seat);
      chk("state", resp_state, e.e_state);
      chk("time", resp_time, e.e_time);
      chk("read_count", rd_log.size() - start, e.e_reads);
      bad = 0;
      for (int i = start; i < rd_log.size(); i++)
        if (rd_log[i] != (e.by_seat ? e.seat : SW'(i - start))) bad++;
      chk("read_addr_seq", bad, 0);
      @(negedge clk);
      chk("resp_drop", resp_valid, 0);
      chk("ready_back", query_ready, 1);
    end
  endtask

  initial begin
    int bad, cyc;
    bit got;
    vec_t v;
    for (int i = 0; i < NS; i++) begin
      t_sn[i] = 1000 + i; t_st[i] = 2'd0; t_tm[i] = TW'(i * 3);
    end
    t_sn[1]  = 201819186; t_st[1]  = 2'd2; t_tm[1]  = 100;
    t_sn[2]  = 201912352; t_st[2]  = 2'd1; t_tm[2]  = 40;
    t_sn[31] = 777;       t_st[31] = 2'd2; t_tm[31] = 2047;

    //            by  seat student    fnd seat st time  lat reads
    vecs[0] = '{1, 1,  0,         1, 1,  2, 100,  3, 1};
    vecs[1] = '{0, 0,  201912352, 1, 2,  1, 40,   5, 4};
    vecs[2] = '{0, 0,  201918757, 0, 0,  0, 0,    34, 32};
    vecs[3] = '{1, 4,  0,         0, 4,  0, 12,   3, 1};
    vecs[4] = '{0, 0,  777,       1, 31, 2, 2047, 34, 32};
    vecs[5] = '{1, 31, 0,         1, 31, 2, 2047, 3, 1};
    vecs[6] = '{0, 0,  1004,      0, 0,  0, 0,    34, 32};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_query_ready", query_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rd_en", tbl_rd_en, 0);
    chk("rst_rd_addr", tbl_rd_addr, 0);
    chk("rst_resp_fields", {resp_found, resp_seat_no, resp_state, resp_time}, 0);
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("post_rst_ready", query_ready, 1);

    foreach (vecs[i]) do_query(vecs[i]);

    // Duplicate student: stale EMPTY seat 0 is skipped, seat 1 beats seat 5.
    t_sn[0] = 2019123179; t_st[0] = 2'd0;
    t_sn[1] = 2019123179; t_st[1] = 2'd2; t_tm[1] = 100;
    t_sn[5] = 2019123179; t_st[5] = 2'd2; t_tm[5] = 55;
    v = '{0, 0, 2019123179, 1, 1, 2, 100, 4, 3};
    do_query(v);

    // Out-of-range direct query on the 20-seat instance.
    @(negedge clk);
    qv20 = 1'b1; query_by_seat = 1'b1; query_seat_no = 5'd31;
    @(posedge clk); #1 qv20 = 1'b0;
    @(negedge clk);
    chk("oor_resp_valid", rv20, 1);
    chk("oor_fields", {found20, seat20, state20, time20}, 0);
    @(negedge clk);
    chk("oor_resp_drop", rv20, 0);
    chk("oor_no_reads", en20_cnt, 0);

    // Backpressure: response held stable for 10 cycles.
    resp_ready = 1'b0;
    v = '{1, 2, 0, 1, 2, 1, 40, 3, 1};
    @(negedge clk);
    query_valid = 1'b1; query_by_seat = 1'b1; query_seat_no = 5'd2;
    sb.push_back(v);
    @(posedge clk); #1 query_valid = 1'b0; query_seat_no = 5'd9;
    cyc = 1; got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
      else begin @(posedge clk); cyc++; end
    end
    v = sb.pop_front();
    chk("bp_resp_seen", got, 1);
    chk("bp_latency", cyc, v.e_lat);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!resp_valid || query_ready || resp_found != v.e_found || resp_seat_no != v.e_seat ||
          resp_state != v.e_state || resp_time != v.e_time) bad++;
    end
    chk("bp_hold_stable", bad, 0);
    @(posedge clk); #1 resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_resp_drop", resp_valid, 0);

    // Reset in the middle of a scan aborts it without a response.
    @(negedge clk);
    query_valid = 1'b1; query_by_seat = 1'b0; query_student_no = 201918757;
    @(posedge clk); #1 query_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_rd_en", tbl_rd_en, 0);
    chk("mid_rst_ready_low", query_ready, 0);
    rst = 1'b0;
    #1 chk("mid_rst_ready_high", query_ready, 1);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid || tbl_rd_en) bad++;
    end
    chk("aborted_no_resp", bad, 0);

    do_query(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
